// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: the NOP filler word and the fetch FSM state type.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_skid.sv
// One-entry skid register: captures the in-flight memory response while the
// decoder is not accepting, and selects it ahead of the live response.
module fetch_skid
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] rsp_insn_i,
  input  logic [31:0] rsp_pc_i,
  output logic        valid_o,
  output logic [31:0] sel_insn_o,
  output logic [31:0] sel_pc_o
);

  logic        valid_q;
  logic [31:0] insn_q;
  logic [31:0] pc_q;

  // Capture/clear the skid entry; clear wins so a redirect always flushes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      insn_q  <= NOP_INSN;
      pc_q    <= 32'h0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      insn_q  <= rsp_insn_i;
      pc_q    <= rsp_pc_i;
    end
  end

  assign valid_o    = valid_q;
  assign sel_insn_o = valid_q ? insn_q : rsp_insn_i;
  assign sel_pc_o   = valid_q ? pc_q   : rsp_pc_i;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency instruction
// memory, and hands insn/pc/run_out to the decoder with a one-entry skid.
// Optional FETCH_PERF_EN adds fetch_count/stall_count performance counters.
//
// state  | meaning
// IDLE   | after reset, waiting for run
// FILL   | fetch_pc presented to memory, no response outstanding yet
// STREAM | response slot valid every cycle, steady-state fetch
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               stall,
  input  logic               redirect_en,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        insn,
  output logic [31:0]        pc,
  output logic               run_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         rsp_v_q, rsp_v_d;
  logic [31:0]  rsp_pc_q, rsp_pc_d;
  logic         skid_load, skid_clear, skid_v;
  logic [31:0]  sel_insn, sel_pc;
  logic         advance;

  assign advance   = run & ~stall;
  assign imem_addr = fetch_pc_q[IMEM_AW+1:2];

  fetch_skid u_skid (
    .clk        (clk),
    .reset      (reset),
    .load_i     (skid_load),
    .clear_i    (skid_clear),
    .rsp_insn_i (imem_rdata),
    .rsp_pc_i   (rsp_pc_q),
    .valid_o    (skid_v),
    .sel_insn_o (sel_insn),
    .sel_pc_o   (sel_pc)
  );

  // State, PC and response-slot registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      rsp_v_q    <= 1'b0;
      rsp_pc_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_v_q    <= rsp_v_d;
      rsp_pc_q   <= rsp_pc_d;
    end
  end

  // Next-state logic; a redirect overrides stall, run=0 and a full skid.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_v_d    = rsp_v_q;
    rsp_pc_d   = rsp_pc_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (redirect_en) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      rsp_v_d    = 1'b0;
      skid_clear = 1'b1;
      state_d    = FILL;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) state_d = FILL;
        end
        FILL: begin
          rsp_v_d    = 1'b1;
          rsp_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = STREAM;
        end
        STREAM: begin
          if (advance) begin
            skid_clear = 1'b1;
            rsp_v_d    = 1'b1;
            rsp_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end else begin
            // Memory re-reads fetch_pc, so the slot tracks it; the word now
            // on imem_rdata is parked in the skid if it is not already full.
            skid_load = rsp_v_q & ~skid_v;
            rsp_pc_d  = fetch_pc_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign run_out = (state_q == STREAM) & run & (skid_v | rsp_v_q);
  assign insn    = run_out ? sel_insn : NOP_INSN;
  assign pc      = run_out ? sel_pc   : 32'h0;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  // Count accepted and stalled valid cycles; both wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else if (run_out) begin
      if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      else       fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the decoder. It owns the program counter, drives a synchronous single-port instruction memory with one-cycle read latency, and presents `insn`/`pc`/`run_out` to the decoder's `insn`/`pc`/`run` inputs. It honours the decoder-side `stall`, takes control-flow redirects from the execute stage, and uses a one-entry skid register so no fetched word is lost or duplicated while stalled.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `IMEM_AW`, 12: instruction memory word-address width.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `run` in 1: core enable; low freezes fetch.
- `stall` in 1: decoder cannot accept this cycle's instruction.
- `redirect_en` in 1: one-cycle pulse, take new PC.
- `redirect_pc` in 32: redirect target; bits [1:0] ignored (forced 0).
- `imem_addr` out IMEM_AW: word address, equals `fetch_pc[IMEM_AW+1:2]`.
- `imem_rdata` in 32: data for the address presented in the previous cycle.
- `insn` out 32: instruction to decoder.
- `pc` out 32: byte address of `insn`.
- `run_out` out 1: `insn`/`pc` valid this cycle.

## Operation
- Registers: `state`, `fetch_pc`, response slot (`rsp_v`, `rsp_pc`), and skid entry (`skid_v`, `skid_pc`, `skid_insn`).
- States: IDLE, FILL, STREAM.
  - IDLE: when `run`=1, go to FILL.
  - FILL: `fetch_pc` is presented. Next edge: `rsp_v`<=1, `rsp_pc`<=`fetch_pc`, `fetch_pc`<=`fetch_pc`+4, go to STREAM.
  - STREAM: steady state; stays until redirect or reset.
- Outputs in STREAM:
  - `run_out` = `run` & (`skid_v` | `rsp_v`).
  - Selected entry is skid if `skid_v`, else `imem_rdata`/`rsp_pc`.
  - When `run_out`=0: `insn`=32'h0000_0013 (NOP), `pc`=0.
- `advance` = `run` & !`stall`.
- STREAM, `advance`=1:
  - `skid_v`<=0.
  - `rsp_v`<=1, `rsp_pc`<=`fetch_pc`.
  - `fetch_pc`<=`fetch_pc`+4.
- STREAM, `advance`=0 (hold):
  - `fetch_pc` holds.
  - If `rsp_v` & !`skid_v`: skid captures (`imem_rdata`, `rsp_pc`), `skid_v`<=1.
  - `rsp_pc`<=`fetch_pc` (re-read). An existing skid entry is unchanged.
- Redirect, in any non-reset state, highest priority (over `stall`, `run`=0, full skid):
  - `fetch_pc`<={`redirect_pc`[31:2],2'b00}.
  - `rsp_v`<=0, `skid_v`<=0, state<=FILL.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Reset: state IDLE, `fetch_pc`=`RESET_PC`, all valid bits 0. Reset mid-stream discards all entries. Reset has priority over redirect.

## Timing
- Reset values: `run_out`=0, `insn`=NOP, `pc`=0, `imem_addr`=`RESET_PC`>>2.
- Start: `run` rises in cycle T (IDLE) → FILL at T+1 → `run_out`=1 with `pc`=`RESET_PC` at T+2.
- Redirect pulse in cycle T → `run_out`=0 at T+1 → target valid at T+2. This is a 1-bubble penalty.
- Throughput: one instruction per cycle while `advance`=1.
- After a hold of any length, the held instruction is presented first, then `pc`+4 in the next cycle, with no gap.
- `run`=0 gates `run_out` low and behaves as a hold. Fetch resumes from the same unconsumed PC.
- `insn`/`pc`/`run_out` are combinational from registers and `imem_rdata`, with no logic from `stall`.

## Configuration
- `FETCH_PERF_EN` defined: adds outputs `fetch_count` (32) and `stall_count` (32). Both reset to 0 and wrap at 2^32.
  - `fetch_count` increments on each cycle with `run_out`&!`stall`.
  - `stall_count` increments on each cycle with `run_out`&`stall`.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared core package holds the `NOP_INSN` constant (32'h0000_0013) and the `fetch_state_t` enum (IDLE, FILL, STREAM).
- One sub-module, `fetch_skid`, holds the one-entry capture/select register with load/clear/select ports. Everything else is in `fetch_unit`.

## Test plan
- Reset, memory word i = 32'h1000+i, `run`=1 at cycle 0 → `run_out` first high at cycle 2 with `pc`=0, `insn`=32'h1000; then `pc` 4, 8 on consecutive cycles.
- `stall` high 3 cycles while `pc`=8 is shown → `pc`=8/`insn`=32'h1002 held 4 cycles, then 12, 16 consecutively with no duplicate or skip.
- `redirect_en` with `redirect_pc`=32'h43 mid-stream → one `run_out`=0 cycle, then `pc`=32'h40, `insn`=32'h1010, then 32'h44.
- `redirect_en` to 32'h80 while `stall`=1 and skid full → skid discarded, `pc`=32'h80 two cycles later.
- Redirect to 32'hFFFF_FFFC with `IMEM_AW`=30 → `pc` 32'hFFFF_FFFC then 32'h0; `reset` asserted mid-stream → next cycle `run_out`=0, `imem_addr`=0.
- With `FETCH_PERF_EN`: 10 accepted plus 3 stalled cycles → `fetch_count`=10, `stall_count`=3.
